apb2axi_apb_cmd_master: RTL and testbench
=========================================

Name: apb2axi_apb_cmd_master

Overview:
APB initiator that drives the APB2AXI register-file gateway from a simple request/stream interface, replacing software-driven register sequencing. For each request it:
- programs ADDR_HI, CMD and ADDR_LO (the ADDR_LO write allocates a directory entry);
- for writes, pushes the data words into the per-tag WR_DATA window;
- polls the per-tag RD_STATUS window until DONE or ERROR;
- for reads, pops the per-tag RD_DATA window onto an output stream.

It sits between a test or host agent and the gateway's APB slave port.

Parameters:
- TAG_NUM, 16, directory entries; tags are assigned round-robin 0..TAG_NUM-1 in allocation order, the same order the directory allocates.
- TAG_STRIDE, 4, byte stride between per-tag words in the STATUS/DATA windows.
- POLL_MAX, 1024, maximum STATUS polls before timeout.
- ADDR_LO_A / ADDR_HI_A / CMD_A / RD_STS_A / RD_DATA_A / WR_DATA_A, package REG_ADDR_* values, register and window base addresses.

Ports:
- pclk  in  1  clock
- presetn  in  1  synchronous active-low reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when valid&ready
- req_is_write  in  1  1 = AXI write, 0 = AXI read
- req_addr  in  2*APB_DATA_W  AXI byte address (hi:lo)
- req_len  in  8  AXI len (beats-1)
- req_size  in  3  AXI size
- wd_valid  in  1  write-data word valid
- wd_ready  out  1  write-data word consumed
- wd_data  in  APB_DATA_W  write-data word
- rd_valid  out  1  read-data word valid
- rd_ready  in  1  downstream ready
- rd_data  out  APB_DATA_W  popped read word
- rd_last  out  1  final beat of request
- rsp_valid  out  1  completion valid
- rsp_ready  in  1  completion accepted
- rsp_resp  out  2  AXI resp from STATUS[13:12]
- rsp_err  out  1  STATUS[14] set, or timeout
- rsp_timeout  out  1  POLL_MAX exhausted
- rsp_tag  out  TAG_W  tag used
- psel, penable, pwrite  out  1  APB control
- paddr  out  APB_ADDR_W  APB address
- pwdata  out  APB_DATA_W  APB write data
- pready, pslverr  in  1  APB response
- prdata  in  APB_DATA_W  APB read data

Behaviour:

Clock and reset:
- One clock, pclk. Reset is synchronous and active-low on presetn.
- All outputs reset to 0, the FSM goes to IDLE, and the tag counter resets to 0.
- Reset mid-transfer drops psel/penable on the next edge; no completion is produced.

APB transfer rules:
- Every APB access is SETUP (psel=1, penable=0, one cycle) then ACCESS (penable=1) held until pready.
- paddr, pwrite and pwdata are stable from SETUP through ACCESS.
- At least one idle cycle (psel=0) separates consecutive accesses.

FSM: IDLE -> W_HI -> W_CMD -> W_LO -> [WDATA] -> POLL -> [POP] -> RESP -> IDLE.
- IDLE: req_ready=1. On handshake, latch the request and the current tag, then increment the tag modulo TAG_NUM.
- W_HI: write req_addr[63:32] to ADDR_HI_A.
- W_CMD: write the CMD word with is_write/len/size in the DIR_ENTRY_* field positions, all other bits 0.
- W_LO: write req_addr[31:0] to ADDR_LO_A. This write must come last, because it triggers allocation.
- WDATA (writes only): req_len+1 writes to WR_DATA_A + tag*TAG_STRIDE.
  - Each write's SETUP starts only when wd_valid=1.
  - wd_ready pulses for one cycle at that ACCESS completion.
- POLL: read RD_STS_A + tag*TAG_STRIDE.
  - Move on when bit15 (DONE) or bit14 (ERROR) is set.
  - Otherwise leave 2 idle cycles and re-poll.
  - Poll count is saturating; reaching POLL_MAX -> RESP with rsp_timeout=1, rsp_err=1, rsp_resp=2'b10.
- POP (reads that are DONE and not ERROR): req_len+1 reads of RD_DATA_A + tag*TAG_STRIDE.
  - A pop's SETUP starts only when the output register is empty or is draining this cycle, so there is no overflow and at most 1 word is buffered.
  - pslverr=1 on a pop: discard prdata, do not count the beat, retry after 1 idle cycle.
  - rd_last is set on beat req_len.
  - A read with ERROR goes straight to RESP with no pops.
- RESP: rsp_valid held until rsp_ready, then IDLE.
  - Captured outputs (rsp_resp, rsp_err, rsp_tag) stay stable while rsp_valid=1.
  - A read completes only after the last rd beat is accepted.

Boundary conditions:
- pslverr on a register write or a STATUS read: flag rsp_err, continue the sequence.
- Beat counter is 9 bits, so len=255 gives 256 beats.
- Tag wraps from TAG_NUM-1 to 0.

Optional Feature:
APB2AXI_MST_POLL_BACKOFF_EN.
- When defined: the idle gap between polls starts at 2 cycles and doubles after each not-done poll, saturating at 64. It resets to 2 per request.
- When undefined: fixed 2-cycle gap.
- Timeout is still counted in polls, not cycles.

Test Plan:
- Read, addr=0x1_0000_0040, len=3, size=2; slave returns DONE on the 3rd poll -> APB writes ADDR_HI=0x1, CMD, ADDR_LO=0x40 in that order; 4 pops at RD_DATA_A+0; rd_last on 4th beat; rsp tag=0, resp=0.
- Write, len=1, wd words 0xA5A5_0001 and 0xA5A5_0002 -> two writes to WR_DATA_A+TAG_STRIDE*tag with those exact pwdata values, then polls; rsp_err=0.
- Pop returns pslverr once on beat 1 -> retried; exactly len+1 words are delivered, in order.
- rd_ready held low 20 cycles mid-burst -> no APB pop is issued while the output word is pending; no data lost.
- STATUS never done -> exactly POLL_MAX polls; rsp_timeout=1, rsp_err=1. Then 17 requests in sequence -> tags 0..15, 0.
- presetn low during ACCESS of a pop -> psel=0 next cycle, all outputs 0, next request uses tag 0.

Source files
------------

// File: rtl/apb2axi_apb_cmd_master.sv
// APB initiator sequencing the APB2AXI gateway: program, push, poll, pop.
// Optional: define APB2AXI_MST_POLL_BACKOFF_EN for exponential poll backoff.
package apb2axi_pkg;
  localparam int APB_DATA_W = 32;
  localparam int APB_ADDR_W = 12;
  localparam logic [11:0] REG_ADDR_ADDR_LO = 12'h000;
  localparam logic [11:0] REG_ADDR_ADDR_HI = 12'h004;
  localparam logic [11:0] REG_ADDR_CMD     = 12'h008;
  localparam logic [11:0] REG_ADDR_RD_STS  = 12'h100;
  localparam logic [11:0] REG_ADDR_RD_DATA = 12'h200;
  localparam logic [11:0] REG_ADDR_WR_DATA = 12'h300;
  localparam int DIR_ENTRY_WR_BIT   = 0;
  localparam int DIR_ENTRY_LEN_LSB  = 8;
  localparam int DIR_ENTRY_SIZE_LSB = 16;
endpackage

module apb2axi_apb_cmd_master
  import apb2axi_pkg::*;
#(
  parameter int TAG_NUM    = 16,
  parameter int TAG_STRIDE = 4,
  parameter int POLL_MAX   = 1024,
  parameter logic [APB_ADDR_W-1:0] ADDR_LO_A = REG_ADDR_ADDR_LO,
  parameter logic [APB_ADDR_W-1:0] ADDR_HI_A = REG_ADDR_ADDR_HI,
  parameter logic [APB_ADDR_W-1:0] CMD_A     = REG_ADDR_CMD,
  parameter logic [APB_ADDR_W-1:0] RD_STS_A  = REG_ADDR_RD_STS,
  parameter logic [APB_ADDR_W-1:0] RD_DATA_A = REG_ADDR_RD_DATA,
  parameter logic [APB_ADDR_W-1:0] WR_DATA_A = REG_ADDR_WR_DATA,
  parameter int TAG_W = $clog2(TAG_NUM)
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_is_write,
  input  logic [2*APB_DATA_W-1:0] req_addr,
  input  logic [7:0]              req_len,
  input  logic [2:0]              req_size,
  input  logic                    wd_valid,
  output logic                    wd_ready,
  input  logic [APB_DATA_W-1:0]   wd_data,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [APB_DATA_W-1:0]   rd_data,
  output logic                    rd_last,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [TAG_W-1:0]        rsp_tag,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [APB_ADDR_W-1:0]   paddr,
  output logic [APB_DATA_W-1:0]   pwdata,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [APB_DATA_W-1:0]   prdata
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_HI, S_W_CMD, S_W_LO,
    S_WDATA, S_POLL, S_POP, S_RESP
  } state_t;

  localparam int PW = $clog2(POLL_MAX + 1);
  localparam logic [APB_ADDR_W-1:0] STRIDE =
    APB_ADDR_W'(TAG_STRIDE);

  state_t st, nx;

  logic                    is_wr_q;
  logic [2*APB_DATA_W-1:0] addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [TAG_W-1:0]        tag_q, tag_cnt;
  logic [8:0]              beat_q, nbeats;
  logic [PW-1:0]           poll_q;
  logic [6:0]              gap_q;
  logic                    err_q, tmo_q;
  logic [1:0]              resp_q;
`ifdef APB2AXI_MST_POLL_BACKOFF_EN
  logic [6:0]              gap_len_q;
`endif

  logic                  acc_done, idle_ok, hit;
  logic                  last_poll, req_hs;
  logic                  start, s_wr;
  logic [APB_ADDR_W-1:0] s_addr, tag_off;
  logic [APB_DATA_W-1:0] s_data, cmd_w;

  assign acc_done  = psel & penable & pready;
  assign idle_ok   = ~psel & (gap_q == 7'd0);
  assign nbeats    = {1'b0, len_q} + 9'd1;
  assign tag_off   = APB_ADDR_W'(tag_q) * STRIDE;
  assign hit       = ~pslverr & (prdata[15] | prdata[14]);
  assign last_poll = (poll_q == PW'(POLL_MAX - 1));
  assign req_hs    = req_valid & req_ready;
  assign wd_ready  = (st == S_WDATA) & acc_done;

  assign rsp_resp    = resp_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = tmo_q;
  assign rsp_tag     = tag_q;

  // State register
  always_ff @(posedge pclk) begin
    if (!presetn) st <= S_IDLE;
    else          st <= nx;
  end

  // Next-state: step through the register program and data phases
  always_comb begin
    nx = st;
    unique case (st)
      S_IDLE:  if (req_hs) nx = S_W_HI;
      S_W_HI:  if (acc_done) nx = S_W_CMD;
      S_W_CMD: if (acc_done) nx = S_W_LO;
      S_W_LO:  if (acc_done) nx = is_wr_q ? S_WDATA : S_POLL;
      S_WDATA:
        if (acc_done && (beat_q + 9'd1 == nbeats)) nx = S_POLL;
      S_POLL:
        if (acc_done) begin
          if (hit)
            nx = (!is_wr_q && !prdata[14]) ? S_POP : S_RESP;
          else if (last_poll)
            nx = S_RESP;
        end
      S_POP:
        if (beat_q == nbeats && (!rd_valid || rd_ready))
          nx = S_RESP;
      S_RESP:  if (rsp_valid && rsp_ready) nx = S_IDLE;
      default: nx = S_IDLE;
    endcase
  end

  // Outputs: decide when to launch an APB access and its address/data
  always_comb begin
    cmd_w = '0;
    cmd_w[DIR_ENTRY_WR_BIT] = is_wr_q;
    cmd_w[DIR_ENTRY_LEN_LSB +: 8] = len_q;
    cmd_w[DIR_ENTRY_SIZE_LSB +: 3] = size_q;
    start  = 1'b0;
    s_wr   = 1'b1;
    s_addr = '0;
    s_data = '0;
    unique case (st)
      S_W_HI: begin
        start  = idle_ok;
        s_addr = ADDR_HI_A;
        s_data = addr_q[2*APB_DATA_W-1:APB_DATA_W];
      end
      S_W_CMD: begin
        start  = idle_ok;
        s_addr = CMD_A;
        s_data = cmd_w;
      end
      S_W_LO: begin
        start  = idle_ok;
        s_addr = ADDR_LO_A;
        s_data = addr_q[APB_DATA_W-1:0];
      end
      S_WDATA: begin
        start  = idle_ok & wd_valid;
        s_addr = WR_DATA_A + tag_off;
        s_data = wd_data;
      end
      S_POLL: begin
        start  = idle_ok;
        s_wr   = 1'b0;
        s_addr = RD_STS_A + tag_off;
      end
      S_POP: begin
        start  = idle_ok & (beat_q != nbeats)
               & (~rd_valid | rd_ready);
        s_wr   = 1'b0;
        s_addr = RD_DATA_A + tag_off;
      end
      default: ;
    endcase
  end

  // Datapath: request latch, APB phases, counters, stream and response
  always_ff @(posedge pclk) begin
    if (!presetn) begin
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      tag_q     <= '0;
      tag_cnt   <= '0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      beat_q    <= '0;
      poll_q    <= '0;
      gap_q     <= '0;
      err_q     <= 1'b0;
      tmo_q     <= 1'b0;
      resp_q    <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
`ifdef APB2AXI_MST_POLL_BACKOFF_EN
      gap_len_q <= 7'd2;
`endif
    end else begin
      req_ready <= (nx == S_IDLE);
      rsp_valid <= (nx == S_RESP);
      if (req_hs) begin
        is_wr_q <= req_is_write;
        addr_q  <= req_addr;
        len_q   <= req_len;
        size_q  <= req_size;
        tag_q   <= tag_cnt;
        tag_cnt <= (tag_cnt == TAG_W'(TAG_NUM - 1)) ?
                   '0 : tag_cnt + 1'b1;
        err_q   <= 1'b0;
        tmo_q   <= 1'b0;
        resp_q  <= '0;
        poll_q  <= '0;
`ifdef APB2AXI_MST_POLL_BACKOFF_EN
        gap_len_q <= 7'd2;
`endif
      end
      if (start) begin
        psel    <= 1'b1;
        penable <= 1'b0;
        paddr   <= s_addr;
        pwrite  <= s_wr;
        pwdata  <= s_data;
      end else if (psel && !penable) begin
        penable <= 1'b1;
      end else if (acc_done) begin
        psel    <= 1'b0;
        penable <= 1'b0;
      end
      if (st != nx)
        beat_q <= '0;
      else if (acc_done && (st == S_WDATA ||
               (st == S_POP && !pslverr)))
        beat_q <= beat_q + 9'd1;
      if (acc_done && pslverr && st != S_POP)
        err_q <= 1'b1;
      if (st == S_POLL && acc_done) begin
        if (poll_q != PW'(POLL_MAX))
          poll_q <= poll_q + 1'b1;
        if (hit) begin
          resp_q <= prdata[13:12];
          if (prdata[14]) err_q <= 1'b1;
        end else if (last_poll) begin
          tmo_q  <= 1'b1;
          err_q  <= 1'b1;
          resp_q <= 2'b10;
        end else begin
`ifdef APB2AXI_MST_POLL_BACKOFF_EN
          gap_q     <= gap_len_q - 7'd1;
          gap_len_q <= (gap_len_q >= 7'd32) ?
                       7'd64 : {gap_len_q[5:0], 1'b0};
`else
          gap_q <= 7'd1;
`endif
        end
      end else if (!psel && gap_q != 7'd0) begin
        gap_q <= gap_q - 7'd1;
      end
      if (st == S_POP && acc_done && !pslverr) begin
        rd_valid <= 1'b1;
        rd_data  <= prdata;
        rd_last  <= (beat_q == {1'b0, len_q});
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb2axi_apb_cmd_master.sv
// Directed bench for apb2axi_apb_cmd_master with an APB slave model.
// Covers read/write sequencing, pop retry, backpressure, timeout, tags, reset.
module tb_apb2axi_apb_cmd_master;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        req_valid, req_ready, req_is_write;
  logic [63:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
  logic [1:0]  rsp_resp;
  logic [3:0]  rsp_tag;
  logic        psel, penable, pwrite, pready, pslverr;
  logic [11:0] paddr;
  logic [31:0] pwdata, prdata;

  apb2axi_apb_cmd_master dut (
    .pclk(pclk), .presetn(presetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_is_write(req_is_write), .req_addr(req_addr),
    .req_len(req_len), .req_size(req_size),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_resp(rsp_resp), .rsp_err(rsp_err),
    .rsp_timeout(rsp_timeout), .rsp_tag(rsp_tag),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .pready(pready), .pslverr(pslverr), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  int n_checks = 0;
  int n_errs = 0;

  // slave model state
  int sts_polls = 0, pop_ok = 0, pop_errs = 0;
  int sts_base = 0, pop_base = 0, perr_base = 0;
  int done_at = 1, perr_beat = -1;
  logic sts_err_bit = 1'b0;
  logic [1:0] sts_resp_v = 2'b00;
  logic slv_stall = 1'b0;
  logic win_sts, win_dat;
  logic [11:0] la[$];
  logic        lw[$];
  logic [31:0] ld[$];
  int b2b_viol = 0, stab_viol = 0, pend_viol = 0;
  logic last_done = 1'b0, pend_prev = 1'b0;
  logic [11:0] prev_paddr = '0;
  logic [31:0] prev_pwdata = '0;

  assign win_sts = (paddr >= 12'h100) && (paddr < 12'h140);
  assign win_dat = (paddr >= 12'h200) && (paddr < 12'h240);

  always_comb begin
    prdata  = '0;
    pslverr = 1'b0;
    pready  = psel & penable & ~(win_dat & slv_stall);
    if (win_sts && done_at != 0 &&
        (sts_polls - sts_base + 1) >= done_at)
      prdata = {16'h0, 1'b1, sts_err_bit, sts_resp_v, 12'h0};
    if (win_dat) begin
      prdata  = 32'hD000_0000 + 32'(pop_ok - pop_base);
      pslverr = (perr_beat >= 0) &&
                ((pop_ok - pop_base) == perr_beat) &&
                (pop_errs == perr_base);
    end
  end

  always @(posedge pclk) begin
    if (psel && penable && pready) begin
      la.push_back(paddr);
      lw.push_back(pwrite);
      ld.push_back(pwdata);
      if (win_sts && !pwrite) sts_polls <= sts_polls + 1;
      if (win_dat && !pwrite) begin
        if (pslverr) pop_errs <= pop_errs + 1;
        else         pop_ok   <= pop_ok + 1;
      end
    end
    if (presetn) begin
      if (psel && !penable && last_done) b2b_viol <= b2b_viol + 1;
      if (psel && penable &&
          (paddr !== prev_paddr || pwdata !== prev_pwdata))
        stab_viol <= stab_viol + 1;
      if (pend_prev && psel && !penable && win_dat)
        pend_viol <= pend_viol + 1;
    end
    last_done   <= psel & penable & pready;
    prev_paddr  <= paddr;
    prev_pwdata <= pwdata;
    pend_prev   <= rd_valid & ~rd_ready;
  end

  task automatic chk(input string t, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=%0h expected=%0h", t, obs, exp);
    end
  endtask

  task automatic chk_log(input string t, input int i,
                         input logic [11:0] a, input logic w,
                         input logic [31:0] d);
    logic [63:0] obs, exp;
    obs = 'x;
    if (i < la.size())
      obs = {19'h0, lw[i], la[i], lw[i] ? ld[i] : 32'h0};
    exp = {19'h0, w, a, w ? d : 32'h0};
    chk(t, obs, exp);
  endtask

  function automatic int cnt_log(input int from, input logic [11:0] a);
    int n = 0;
    for (int i = from; i < la.size(); i++)
      if (la[i] == a && !lw[i]) n++;
    return n;
  endfunction

  task automatic cfg(input int d_at, input logic e,
                     input logic [1:0] r, input int pb);
    done_at = d_at; sts_err_bit = e; sts_resp_v = r;
    perr_beat = pb;
    sts_base = sts_polls; pop_base = pop_ok;
    perr_base = pop_errs;
  endtask

  logic        cur_wr;
  logic [7:0]  cur_len;
  logic [31:0] rx_d[$];
  logic        rx_l[$];
  logic [1:0]  r_resp;
  logic        r_err, r_tmo, stab_bad;
  logic [3:0]  r_tag;

  task automatic start_req(input logic wr, input logic [63:0] a,
                           input logic [7:0] l, input logic [2:0] s);
    int n = 0;
    @(negedge pclk);
    cur_wr = wr; cur_len = l;
    req_valid = 1'b1; req_is_write = wr;
    req_addr = a; req_len = l; req_size = s;
    while (!req_ready && n < 50) begin
      @(negedge pclk);
      n++;
    end
    chk("req_accept", req_ready, 1);
    @(posedge pclk);
    #1 req_valid = 1'b0;
  endtask

  task automatic finish_req(input int hold_at, input int hold_n,
                            input int budget);
    int wi = 0, hc = 0, seen = 0;
    logic done = 1'b0;
    rx_d.delete(); rx_l.delete();
    stab_bad = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge pclk);
      wd_valid = cur_wr && (wi <= int'(cur_len));
      wd_data  = 32'hA5A5_0001 + 32'(wi);
      if (rx_d.size() == hold_at && hc < hold_n) begin
        rd_ready = 1'b0;
        hc++;
      end else begin
        rd_ready = 1'b1;
      end
      rsp_ready = (seen >= 2);
      #1;
      if (wd_valid && wd_ready) wi++;
      if (rd_valid && rd_ready) begin
        rx_d.push_back(rd_data);
        rx_l.push_back(rd_last);
      end
      if (rsp_valid) begin
        if (seen == 0) begin
          r_resp = rsp_resp; r_err = rsp_err;
          r_tmo = rsp_timeout; r_tag = rsp_tag;
        end else if ({rsp_resp, rsp_err, rsp_timeout, rsp_tag} !==
                     {r_resp, r_err, r_tmo, r_tag}) begin
          stab_bad = 1'b1;
        end
        seen++;
        if (rsp_ready) done = 1'b1;
      end
    end
    chk("rsp_done", done, 1);
    @(negedge pclk);
    wd_valid = 1'b0; rsp_ready = 1'b0; rd_ready = 1'b1;
  endtask

  initial begin
    int lb, n;
    presetn = 1'b0; req_valid = 1'b0; req_is_write = 1'b0;
    req_addr = '0; req_len = '0; req_size = '0;
    wd_valid = 1'b0; wd_data = '0;
    rd_ready = 1'b1; rsp_ready = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wd_ready", wd_ready, 0);
    @(negedge pclk) presetn = 1'b1;
    @(posedge pclk) #1;
    chk("idle_req_ready", req_ready, 1);

    // read, DONE on 3rd poll
    cfg(3, 1'b0, 2'b00, -1);
    lb = la.size();
    start_req(1'b0, 64'h1_0000_0040, 8'd3, 3'd2);
    finish_req(-1, 0, 500);
    chk_log("t1_hi", lb + 0, 12'h004, 1, 32'h1);
    chk_log("t1_cmd", lb + 1, 12'h008, 1, 32'h0002_0300);
    chk_log("t1_lo", lb + 2, 12'h000, 1, 32'h40);
    for (int k = 0; k < 3; k++)
      chk_log($sformatf("t1_poll%0d", k), lb + 3 + k, 12'h100, 0, 0);
    for (int k = 0; k < 4; k++)
      chk_log($sformatf("t1_pop%0d", k), lb + 6 + k, 12'h200, 0, 0);
    chk("t1_log_len", la.size() - lb, 10);
    chk("t1_nwords", rx_d.size(), 4);
    for (int k = 0; k < rx_d.size(); k++) begin
      chk($sformatf("t1_word%0d", k), rx_d[k], 32'hD000_0000 + k);
      chk($sformatf("t1_last%0d", k), rx_l[k], k == 3);
    end
    chk("t1_tag", r_tag, 0);
    chk("t1_resp", r_resp, 0);
    chk("t1_err", r_err, 0);
    chk("t1_rsp_stable", stab_bad, 0);

    // write, two data words
    cfg(1, 1'b0, 2'b00, -1);
    lb = la.size();
    start_req(1'b1, 64'h2_0000_1000, 8'd1, 3'd2);
    finish_req(-1, 0, 500);
    chk_log("t2_hi", lb + 0, 12'h004, 1, 32'h2);
    chk_log("t2_cmd", lb + 1, 12'h008, 1, 32'h0002_0101);
    chk_log("t2_lo", lb + 2, 12'h000, 1, 32'h1000);
    chk_log("t2_wd0", lb + 3, 12'h304, 1, 32'hA5A5_0001);
    chk_log("t2_wd1", lb + 4, 12'h304, 1, 32'hA5A5_0002);
    chk_log("t2_poll", lb + 5, 12'h104, 0, 0);
    chk("t2_log_len", la.size() - lb, 6);
    chk("t2_tag", r_tag, 1);
    chk("t2_err", r_err, 0);

    // pop pslverr on beat 1, retried
    cfg(1, 1'b0, 2'b00, 1);
    lb = la.size();
    start_req(1'b0, 64'h80, 8'd3, 3'd2);
    finish_req(-1, 0, 500);
    chk("t3_pop_reads", cnt_log(lb, 12'h208), 5);
    chk("t3_nwords", rx_d.size(), 4);
    for (int k = 0; k < rx_d.size(); k++)
      chk($sformatf("t3_word%0d", k), rx_d[k], 32'hD000_0000 + k);
    chk("t3_tag", r_tag, 2);
    chk("t3_err", r_err, 0);

    // rd_ready low 20 cycles mid-burst
    cfg(1, 1'b0, 2'b00, -1);
    start_req(1'b0, 64'h100, 8'd7, 3'd2);
    finish_req(2, 20, 800);
    chk("t4_nwords", rx_d.size(), 8);
    for (int k = 0; k < rx_d.size(); k++) begin
      chk($sformatf("t4_word%0d", k), rx_d[k], 32'hD000_0000 + k);
      chk($sformatf("t4_last%0d", k), rx_l[k], k == 7);
    end
    chk("t4_pend_viol", pend_viol, 0);
    chk("t4_tag", r_tag, 3);

    // STATUS ERROR on a read: no pops
    cfg(1, 1'b1, 2'b11, -1);
    lb = la.size();
    start_req(1'b0, 64'h200, 8'd2, 3'd2);
    finish_req(-1, 0, 500);
    chk("t5_pops", cnt_log(lb, 12'h210), 0);
    chk("t5_nwords", rx_d.size(), 0);
    chk("t5_err", r_err, 1);
    chk("t5_resp", r_resp, 3);
    chk("t5_tmo", r_tmo, 0);

    // never done: timeout
    cfg(0, 1'b0, 2'b00, -1);
    lb = la.size();
    start_req(1'b0, 64'h300, 8'd0, 3'd2);
    finish_req(-1, 0, 6000);
    chk("t6_polls", sts_polls - sts_base, 1024);
    chk("t6_tmo", r_tmo, 1);
    chk("t6_err", r_err, 1);
    chk("t6_resp", r_resp, 2);
    chk("t6_pops", cnt_log(lb, 12'h214), 0);
    chk("t6_tag", r_tag, 5);

    // tag sequence after reset: 0..15, 0
    @(negedge pclk) presetn = 1'b0;
    repeat (2) @(negedge pclk);
    presetn = 1'b1;
    for (int i = 0; i < 17; i++) begin
      cfg(1, 1'b0, 2'b00, -1);
      start_req(1'b0, 64'h400, 8'd0, 3'd2);
      finish_req(-1, 0, 300);
      chk($sformatf("t7_tag%0d", i), r_tag, i % 16);
    end

    // reset during ACCESS of a pop
    cfg(1, 1'b0, 2'b00, -1);
    slv_stall = 1'b1;
    start_req(1'b0, 64'h500, 8'd3, 3'd2);
    n = 0;
    while (!(psel && penable && win_dat) && n < 200) begin
      @(negedge pclk);
      n++;
    end
    chk("t8_in_pop_access", psel && penable && win_dat, 1);
    presetn = 1'b0;
    @(posedge pclk) #1;
    chk("t8_psel", psel, 0);
    chk("t8_penable", penable, 0);
    chk("t8_paddr", paddr, 0);
    chk("t8_rsp_valid", rsp_valid, 0);
    chk("t8_rd_valid", rd_valid, 0);
    chk("t8_req_ready", req_ready, 0);
    @(negedge pclk);
    presetn = 1'b1;
    slv_stall = 1'b0;
    cfg(1, 1'b0, 2'b00, -1);
    start_req(1'b0, 64'h600, 8'd0, 3'd2);
    finish_req(-1, 0, 300);
    chk("t8_tag_after_rst", r_tag, 0);

    chk("apb_b2b_viol", b2b_viol, 0);
    chk("apb_stab_viol", stab_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errs);
    $finish;
  end

endmodule
